// File: rtl/i2c_master.sv
// -----------------------------------------------------------------------------
// i2c_master
//
// Single-master I2C controller. Each request runs one register write
// (START, {addr,W}, ACK, reg, ACK, data, ACK, STOP) or one register read
// (START, {addr,W}, ACK, reg, ACK, Sr, {addr,R}, ACK, 8 data bits, NACK, STOP).
// Every bus element is four phases of comp+1 clk cycles each.
// SCL is push-pull. SDA is open-drain: it is either driven low or released.
//
// Control handshake: the request is a level. It is accepted on a clk edge
// where tx_rx_req && tr_en are both high while the FSM is idle. At that
// edge, comp, chip_addr, reg_addr, tx_data and wr_rd are latched.
// tx_rx_req_ack pulses for one cycle after STOP. The request is not sampled
// during that ack cycle, so a request that stays high starts a new transaction.
//
// Ports:
//   clk            system clock, rising edge
//   resetn         asynchronous active-low reset
//   comp[9:0]      phase length minus one, in clk cycles
//   chip_addr[6:0] 7-bit slave address
//   reg_addr[7:0]  slave register address
//   tx_data[7:0]   byte to write
//   rx_data[7:0]   byte captured by the last completed read
//   tr_en          master enable (only gates the start of a transaction)
//   tx_rx_req      transaction request (level)
//   tx_rx_req_ack  one-cycle completion pulse
//   wr_rd          1 = write, 0 = read
//   scl            I2C clock
//   sda            I2C data (0 or high-Z)
//
// Build option: I2C_ACK_CHECK_EN. When it is defined, a NACK on any slave
// ACK bit ends the transfer with STOP. When it is undefined, slave ACK
// bits are ignored.
// -----------------------------------------------------------------------------
module i2c_master (
   input  logic       clk,
   input  logic       resetn,
   input  logic [9:0] comp,
   input  logic [6:0] chip_addr,
   input  logic [7:0] reg_addr,
   input  logic [7:0] tx_data,
   output logic [7:0] rx_data,
   input  logic       tr_en,
   input  logic       tx_rx_req,
   output logic       tx_rx_req_ack,
   input  logic       wr_rd,
   output logic       scl,
   inout  wire        sda
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_LOAD, ST_START, ST_BYTE, ST_RSTART, ST_STOP, ST_DONE
   } state_t;

   state_t     state, state_nxt;
   logic [9:0] comp_q;
   logic [6:0] chip_q;
   logic [7:0] reg_q;
   logic [7:0] data_q;
   logic       wr_q;
   logic [9:0] div_cnt;
   logic [1:0] phase;
   logic [3:0] bit_cnt;    // 0..7 data bits, 8 = ACK/NACK bit
   logic [1:0] byte_idx;   // 0 addr+W, 1 reg, 2 data or addr+R, 3 read byte
   logic [7:0] rx_shift;
   logic [7:0] tx_byte;
   logic       phase_end, elem_end, ack_bit, reading, last_byte;
   logic       sda_in, sda_low, abort;

   assign phase_end = (div_cnt == comp_q);
   assign elem_end  = phase_end && (phase == 2'd3);
   assign ack_bit   = (bit_cnt == 4'd8);
   assign reading   = !wr_q && (byte_idx == 2'd3);
   assign last_byte = wr_q ? (byte_idx == 2'd2) : (byte_idx == 2'd3);

   assign sda = sda_low ? 1'b0 : 1'bz;

   // Anything other than a solid low counts as 1. This includes Z and X,
   // so a floating line reads as NACK.
   always_comb begin
      if (sda == 1'b0) sda_in = 1'b0;
      else             sda_in = 1'b1;
   end

   always_comb begin
      case (byte_idx)
         2'd0:    tx_byte = {chip_q, 1'b0};
         2'd1:    tx_byte = reg_q;
         2'd2:    tx_byte = wr_q ? data_q : {chip_q, 1'b1};
         default: tx_byte = 8'hFF;
      endcase
   end

`ifdef I2C_ACK_CHECK_EN
   logic nack_q;
   assign abort = nack_q && !reading;
`else
   assign abort = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (tx_rx_req && tr_en) state_nxt = ST_LOAD;
         ST_LOAD:   state_nxt = ST_START;
         ST_START:  if (elem_end) state_nxt = ST_BYTE;
         ST_BYTE: begin
            if (elem_end && ack_bit) begin
               if (abort || last_byte)               state_nxt = ST_STOP;
               else if (!wr_q && byte_idx == 2'd1)   state_nxt = ST_RSTART;
            end
         end
         ST_RSTART: if (elem_end) state_nxt = ST_BYTE;
         ST_STOP:   if (elem_end) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Output logic: per-phase bus levels for each element type
   always_comb begin
      scl           = 1'b1;
      sda_low       = 1'b0;
      tx_rx_req_ack = (state == ST_DONE);
      case (state)
         ST_START:  sda_low = phase[1];
         ST_RSTART: begin
            scl     = (phase != 2'd0);
            sda_low = phase[1];
         end
         ST_STOP: begin
            scl     = (phase != 2'd0);
            sda_low = !phase[1];
         end
         ST_BYTE: begin
            scl = phase[1];
            // The master drives only address/register/data bits.
            // ACK bits and all read-byte bits (including the master NACK)
            // are released.
            sda_low = !ack_bit && !reading && !tx_byte[~bit_cnt[2:0]];
         end
         default: ;
      endcase
   end

   // Datapath: request latch, phase divider, bit/byte counters, capture
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         comp_q   <= '0;
         chip_q   <= '0;
         reg_q    <= '0;
         data_q   <= '0;
         wr_q     <= 1'b0;
         div_cnt  <= '0;
         phase    <= '0;
         bit_cnt  <= '0;
         byte_idx <= '0;
         rx_shift <= '0;
         rx_data  <= '0;
`ifdef I2C_ACK_CHECK_EN
         nack_q   <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               div_cnt  <= '0;
               phase    <= '0;
               bit_cnt  <= '0;
               byte_idx <= '0;
               if (tx_rx_req && tr_en) begin
                  comp_q <= comp;
                  chip_q <= chip_addr;
                  reg_q  <= reg_addr;
                  data_q <= tx_data;
                  wr_q   <= wr_rd;
               end
            end
            ST_START, ST_BYTE, ST_RSTART, ST_STOP: begin
               if (!phase_end) begin
                  div_cnt <= div_cnt + 10'd1;
               end else begin
                  div_cnt <= '0;
                  phase   <= phase + 2'd1;
                  // SDA is sampled at the end of phase 2, while SCL is high.
                  if (state == ST_BYTE && phase == 2'd2 && !ack_bit)
                     rx_shift <= {rx_shift[6:0], sda_in};
`ifdef I2C_ACK_CHECK_EN
                  if (state == ST_BYTE && phase == 2'd2 && ack_bit && !reading)
                     nack_q <= sda_in;
`endif
                  if (state == ST_BYTE && phase == 2'd3) begin
                     if (ack_bit) begin
                        bit_cnt  <= '0;
                        byte_idx <= byte_idx + 2'd1;
                        if (reading) rx_data <= rx_shift;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_master.sv
// -----------------------------------------------------------------------------
// tb_i2c_master
//
// Bench for i2c_master. For each transaction, a reference model builds the
// expected bus waveform as a queue of phases. Each entry holds the SCL
// level, whether the master releases SDA, and whether the slave pulls SDA
// low. The model works from the element tables (START/Sr/STOP/bit) and the
// transaction layouts. The bench then expands each phase to comp+1 cycles,
// drives the slave side from the queue, and checks SCL, SDA and the ack
// pulse every cycle. It also checks rx_data at completion.
// -----------------------------------------------------------------------------
module tb_i2c_master;

   logic       clk = 1'b0;
   logic       resetn;
   logic [9:0] comp;
   logic [6:0] chip_addr;
   logic [7:0] reg_addr;
   logic [7:0] tx_data;
   logic [7:0] rx_data;
   logic       tr_en;
   logic       tx_rx_req;
   logic       tx_rx_req_ack;
   logic       wr_rd;
   logic       scl;
   wire        sda;
   logic       slave_low;

   assign sda = slave_low ? 1'b0 : 1'bz;
   pullup (sda);

`ifdef I2C_ACK_CHECK_EN
   localparam bit ACK_CHECK = 1'b1;
`else
   localparam bit ACK_CHECK = 1'b0;
`endif

   i2c_master dut (
      .clk           (clk),
      .resetn        (resetn),
      .comp          (comp),
      .chip_addr     (chip_addr),
      .reg_addr      (reg_addr),
      .tx_data       (tx_data),
      .rx_data       (rx_data),
      .tr_en         (tr_en),
      .tx_rx_req     (tx_rx_req),
      .tx_rx_req_ack (tx_rx_req_ack),
      .wr_rd         (wr_rd),
      .scl           (scl),
      .sda           (sda)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int         total = 0;
   int         bad   = 0;
   logic [2:0] exp_q[$];   // per phase: {scl, master releases sda, slave pulls low}
   logic [7:0] exp_rx;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // s/d are the four phase values, phase 0 first (msb).
   task automatic put_elem(input logic [3:0] s, input logic [3:0] d, input logic pull);
      for (int p = 0; p < 4; p++) exp_q.push_back({s[3-p], d[3-p], pull});
   endtask

   task automatic put_bit(input logic rel, input logic pull);
      put_elem(4'b0011, {4{rel}}, pull);
   endtask

   task automatic put_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) put_bit(b[i], 1'b0);
   endtask

   task automatic build_model(input logic wr, input logic [6:0] ca, input logic [7:0] ra,
                              input logic [7:0] td, input logic [7:0] rd, input logic present);
      logic abort;
      exp_q.delete();
      abort = 1'b0;
      put_elem(4'b1111, 4'b1100, 1'b0);                 // START
      put_byte({ca, 1'b0});
      put_bit(1'b1, present);
      abort = ACK_CHECK && !present;
      if (!abort) begin
         put_byte(ra);
         put_bit(1'b1, present);
         abort = ACK_CHECK && !present;
      end
      if (!abort && wr) begin
         put_byte(td);
         put_bit(1'b1, present);
      end
      if (!abort && !wr) begin
         put_elem(4'b0111, 4'b1100, 1'b0);              // repeated START
         put_byte({ca, 1'b1});
         put_bit(1'b1, present);
         abort = ACK_CHECK && !present;
         if (!abort) begin
            for (int i = 7; i >= 0; i--) put_bit(1'b1, present & ~rd[i]);
            put_bit(1'b1, 1'b0);                        // master NACK
            exp_rx = present ? rd : 8'hFF;
         end
      end
      put_elem(4'b0111, 4'b0011, 1'b0);                 // STOP
   endtask

   // ---------------- driver ----------------
   // gap: DUT is in its ack cycle now, so one idle cycle precedes the sample edge.
   task automatic run_txn(input logic wr, input logic [9:0] c, input logic [6:0] ca,
                          input logic [7:0] ra, input logic [7:0] td, input logic [7:0] rd,
                          input logic present, input logic gap, input logic hold,
                          input logic drop_en);
      logic [2:0] e;
      build_model(wr, ca, ra, td, rd, present);
      comp = c; chip_addr = ca; reg_addr = ra; tx_data = td; wr_rd = wr;
      tr_en = 1'b1; tx_rx_req = 1'b1;
      if (gap) begin
         @(posedge clk);
         @(negedge clk);
         check("gap_scl", 32'(scl), 32'd1);
         check("gap_ack", 32'(tx_rx_req_ack), 32'd0);
      end
      @(posedge clk);                                    // request sample edge
      @(negedge clk);
      check("load_scl", 32'(scl), 32'd1);
      check("load_sda", 32'(sda), 32'd1);
      // Latched inputs must be unaffected by later changes.
      comp = 10'($urandom_range(1023, 0)); chip_addr = 7'($urandom);
      reg_addr = 8'($urandom); tx_data = 8'($urandom); wr_rd = 1'($urandom);
      if (!hold)   tx_rx_req = 1'b0;
      if (drop_en) tr_en = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         e = exp_q[i];
         for (int k = 0; k <= int'(c); k++) begin
            @(posedge clk);
            #1 slave_low = e[0];
            @(negedge clk);
            check("scl", 32'(scl), 32'(e[2]));
            check("sda", 32'(sda), 32'(e[1] & ~e[0]));
            check("ack_early", 32'(tx_rx_req_ack), 32'd0);
         end
      end
      @(posedge clk);
      #1 slave_low = 1'b0;
      @(negedge clk);
      check("ack", 32'(tx_rx_req_ack), 32'd1);
      check("rx_data", 32'(rx_data), 32'(exp_rx));
      check("end_scl", 32'(scl), 32'd1);
      check("end_sda", 32'(sda), 32'd1);
      tr_en = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   logic [9:0] comps [10];

   initial begin
      comps = '{10'd0, 10'd1, 10'd2, 10'd4, 10'd8, 10'd16, 10'd32, 10'd64, 10'd128, 10'd3};
      resetn = 1'b0; tr_en = 1'b1; tx_rx_req = 1'b0; slave_low = 1'b0;
      comp = '0; chip_addr = '0; reg_addr = '0; tx_data = '0; wr_rd = 1'b0;
      exp_rx = 8'h00;

      // reset
      repeat (7) @(negedge clk);
      check("rst_scl", 32'(scl), 32'd1);
      check("rst_sda", 32'(sda), 32'd1);
      check("rst_rx", 32'(rx_data), 32'd0);
      check("rst_ack", 32'(tx_rx_req_ack), 32'd0);
      resetn = 1'b1;

      // directed write and read
      run_txn(1'b1, 10'd0, 7'h50, 8'hA5, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      run_txn(1'b0, 10'd1, 7'h21, 8'h10, 8'h00, 8'h96, 1'b1, 1'b1, 1'b0, 1'b0);

      // reset in the middle of a read: immediate release, no STOP
      comp = 10'd0; wr_rd = 1'b0; chip_addr = 7'h33; reg_addr = 8'h44; tx_rx_req = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tx_rx_req = 1'b0;
      repeat (40) @(negedge clk);
      resetn = 1'b0;
      #1;
      exp_rx = 8'h00;
      check("midrst_scl", 32'(scl), 32'd1);
      check("midrst_sda", 32'(sda), 32'd1);
      check("midrst_ack", 32'(tx_rx_req_ack), 32'd0);
      check("midrst_rx", 32'(rx_data), 32'd0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("post_rst_scl", 32'(scl), 32'd1);
         check("post_rst_sda", 32'(sda), 32'd1);
      end

      // tr_en low blocks the start; raising it starts the transaction
      tr_en = 1'b0; tx_rx_req = 1'b1;
      repeat (20) begin
         @(negedge clk);
         check("gated_scl", 32'(scl), 32'd1);
         check("gated_sda", 32'(sda), 32'd1);
         check("gated_ack", 32'(tx_rx_req_ack), 32'd0);
      end
      run_txn(1'($urandom), 10'd1, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              1'b1, 1'b0, 1'b0, 1'b1);

      // back-to-back with a held request across the bit-rate sweep
      for (int t = 0; t < 10; t++)
         run_txn((comps[t] >= 10'd128) ? 1'b1 : 1'($urandom), comps[t], 7'($urandom),
                 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b1, 1'b0);

      // no slave on the bus
      run_txn(1'b1, 10'd2, 7'($urandom), 8'($urandom), 8'($urandom), 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      run_txn(1'b0, 10'd0, 7'($urandom), 8'($urandom), 8'($urandom), 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

      // a few more random transactions
      for (int t = 0; t < 4; t++)
         run_txn(1'($urandom), 10'($urandom_range(3, 0)), 7'($urandom), 8'($urandom),
                 8'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
